// File: rtl/stair_count_seg7.sv
// Staircase counter on one active-low 7-segment digit.
// Each run counts 0..limit (ascending) or limit..0 (descending); after every
// run the limit advances 1..LIMIT_MAX and wraps. Steps are paced by a
// prescaler-derived clock enable whose rate is chosen by sw.
module stair_count_seg7 #(
  parameter int DIV_W     = 26,
  parameter int LIMIT_MAX = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw,
  input  logic       dir,
  input  logic       pause,
  output logic [6:0] seg0,
  output logic [3:0] count,
  output logic [3:0] limit,
  output logic       tick,
  output logic       run_done
);

  localparam logic [3:0] LIM_MAX_4 = 4'(LIMIT_MAX);

  // Prescaler masks: a tick fires when the low k bits of the divider are all ones.
  logic [DIV_W-1:0] mask_slow;
  logic [DIV_W-1:0] mask_mid;
  logic [DIV_W-1:0] mask_fast;

  genvar gi;
  generate
    for (gi = 0; gi < DIV_W; gi++) begin : g_mask
      assign mask_slow[gi] = 1'b1;
      assign mask_mid[gi]  = (gi < DIV_W - 1);
      assign mask_fast[gi] = (gi < DIV_W - 2);
    end
  endgenerate

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] tick_mask;
  logic             raw_tick;
  logic             tick_reg;
  logic             step;

  logic [3:0] count_reg, count_next;
  logic [3:0] limit_reg, limit_next;
  logic       run_dir_reg, run_dir_next;
  logic       run_done_reg, run_done_next;
  logic [6:0] seg_reg;
  logic [3:0] limit_wrap;

  // Active-low {g,f,e,d,c,b,a} hex decode.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Select the tick period from sw; the mask is applied to the live divider,
  // so a speed change simply waits for the next matching divider value.
  always_comb begin
    case (sw)
      2'b00:   tick_mask = mask_slow;
      2'b10:   tick_mask = mask_mid;
      default: tick_mask = mask_fast;
    endcase
    raw_tick = ((div_reg & tick_mask) == tick_mask);
  end

  // Free-running divider and registered tick enable (keeps running under pause).
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      div_reg  <= div_reg + 1'b1;
      tick_reg <= raw_tick;
    end
  end

  assign step       = tick_reg & ~pause;
  assign limit_wrap = (limit_reg == LIM_MAX_4) ? 4'd1 : limit_reg + 4'd1;

  // Next-state of the staircase: step within the run, or close it and start the next.
  always_comb begin
    count_next    = count_reg;
    limit_next    = limit_reg;
    run_dir_next  = run_dir_reg;
    run_done_next = 1'b0;
    if (step) begin
      if (!run_dir_reg && (count_reg != limit_reg)) begin
        count_next = count_reg + 4'd1;
      end else if (run_dir_reg && (count_reg != 4'd0)) begin
        count_next = count_reg - 4'd1;
      end else begin
        limit_next    = limit_wrap;
        run_dir_next  = dir;
        count_next    = dir ? limit_wrap : 4'd0;
        run_done_next = 1'b1;
      end
    end
  end

  // Run state and display; the digit is decoded from count_next so it tracks count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg    <= 4'd0;
      limit_reg    <= 4'd1;
      run_dir_reg  <= 1'b0;
      run_done_reg <= 1'b0;
      seg_reg      <= 7'b1000000;
    end else begin
      count_reg    <= count_next;
      limit_reg    <= limit_next;
      run_dir_reg  <= run_dir_next;
      run_done_reg <= run_done_next;
      seg_reg      <= seg_decode(count_next);
    end
  end

  assign seg0     = seg_reg;
  assign count    = count_reg;
  assign limit    = limit_reg;
  assign tick     = tick_reg;
  assign run_done = run_done_reg;

endmodule

// File: tb/tb_stair_count_seg7.sv
// Randomised bench for stair_count_seg7 against a behavioural staircase model.
// Instance A: LIMIT_MAX=3 driven through directed phases and random traffic.
// Instance B: LIMIT_MAX=15 at the fastest rate, run up to limit 15 and its wrap.
module tb_stair_count_seg7;

  localparam int DIV_W = 4;

  typedef struct {
    int div;
    int cnt;
    int lim;
    int rdir;
    int tick;
    int done;
  } model_t;

  logic       clk = 1'b0;
  logic       rst, rst_b;
  logic [1:0] sw_a;
  logic       dir_a, pause_a;
  logic [6:0] seg_a, seg_b;
  logic [3:0] count_a, limit_a, count_b, limit_b;
  logic       tick_a, done_a, tick_b, done_b;

  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  model_t ma, mb;
  int n_tests = 0;
  int n_fail  = 0;
  int prev_lim_b = 0;
  bit saw_f_b = 1'b0;
  bit saw_wrap_b = 1'b0;

  stair_count_seg7 #(.DIV_W(DIV_W), .LIMIT_MAX(3)) dut_a (
    .clk(clk), .rst(rst), .sw(sw_a), .dir(dir_a), .pause(pause_a),
    .seg0(seg_a), .count(count_a), .limit(limit_a), .tick(tick_a), .run_done(done_a)
  );

  stair_count_seg7 #(.DIV_W(DIV_W), .LIMIT_MAX(15)) dut_b (
    .clk(clk), .rst(rst_b), .sw(2'b01), .dir(1'b0), .pause(1'b0),
    .seg0(seg_b), .count(count_b), .limit(limit_b), .tick(tick_b), .run_done(done_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // State after one clock edge, from the staircase rules in plain arithmetic.
  function automatic model_t model_next(model_t s, bit r, bit [1:0] sw_v, bit dir_v,
                                        bit pause_v, int lmax);
    model_t n;
    int p;
    int nl;
    n = s;
    if (r) begin
      n.div = 0; n.cnt = 0; n.lim = 1; n.rdir = 0; n.tick = 0; n.done = 0;
      return n;
    end
    p = (sw_v == 2'b00) ? (1 << DIV_W) : (sw_v == 2'b10) ? (1 << (DIV_W - 1)) : (1 << (DIV_W - 2));
    n.done = 0;
    if (s.tick == 1 && !pause_v) begin
      if (s.rdir == 0 && s.cnt < s.lim) n.cnt = s.cnt + 1;
      else if (s.rdir == 1 && s.cnt > 0) n.cnt = s.cnt - 1;
      else begin
        nl     = (s.lim == lmax) ? 1 : s.lim + 1;
        n.lim  = nl;
        n.rdir = dir_v;
        n.cnt  = dir_v ? nl : 0;
        n.done = 1;
      end
    end
    n.tick = ((s.div % p) == p - 1) ? 1 : 0;
    n.div  = (s.div + 1) % (1 << DIV_W);
    return n;
  endfunction

  task automatic compare_all();
    check("a_count", 32'(count_a), 32'(ma.cnt));
    check("a_limit", 32'(limit_a), 32'(ma.lim));
    check("a_tick",  32'(tick_a),  32'(ma.tick));
    check("a_done",  32'(done_a),  32'(ma.done));
    check("a_seg0",  32'(seg_a),   32'(seg_tbl[ma.cnt]));
    check("b_count", 32'(count_b), 32'(mb.cnt));
    check("b_limit", 32'(limit_b), 32'(mb.lim));
    check("b_tick",  32'(tick_b),  32'(mb.tick));
    check("b_done",  32'(done_b),  32'(mb.done));
    check("b_seg0",  32'(seg_b),   32'(seg_tbl[mb.cnt]));
    if (count_b == 4'd15 && seg_b == 7'b0001110) saw_f_b = 1'b1;
    if (prev_lim_b == 15 && limit_b == 4'd1) saw_wrap_b = 1'b1;
    prev_lim_b = int'(limit_b);
  endtask

  // One clock: advance the models with the inputs now applied, then compare mid-cycle.
  task automatic cycle();
    ma = model_next(ma, rst, sw_a, dir_a, pause_a, 3);
    mb = model_next(mb, rst_b, 2'b01, 1'b0, 1'b0, 15);
    @(negedge clk);
    compare_all();
    if (ma.done == 1)
      $display("[TB] t=%0t run end: limit=%0d count=%0d dir=%0d", $time, ma.lim, ma.cnt, ma.rdir);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bit found;
    ma = '{0, 0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0, 0};
    rst = 1'b1; rst_b = 1'b1; sw_a = 2'b00; dir_a = 1'b0; pause_a = 1'b0;
    run(2);
    rst = 1'b0; rst_b = 1'b0;

    // Slow ascending staircase.
    run(200);

    // Speed changes slow -> mid -> fast.
    sw_a = 2'b00; run(40);
    sw_a = 2'b10; run(40);
    sw_a = 2'b01; run(40);

    // Flip dir mid-run at count=1, limit=2 ascending.
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (count_a == 4'd1 && limit_a == 4'd2 && ma.rdir == 0) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    check("t3_reach", 32'(found), 32'd1);
    dir_a = 1'b1;
    run(200);

    // Pause across several ticks.
    pause_a = 1'b1; run(50);
    pause_a = 1'b0; run(40);

    // Reset coincident with a tick while count=2.
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (count_a == 4'd2 && tick_a == 1'b1) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    check("t6_reach", 32'(found), 32'd1);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("t6_count", 32'(count_a), 32'd0);
    check("t6_limit", 32'(limit_a), 32'd1);
    check("t6_seg0",  32'(seg_a),   32'(7'b1000000));
    check("t6_done",  32'(done_a),  32'd0);
    check("t6_tick",  32'(tick_a),  32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) sw_a = 2'($urandom_range(0, 3));
      dir_a = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) pause_a = ~pause_a;
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;

    check("b_saw_F", 32'(saw_f_b), 32'd1);
    check("b_wrap",  32'(saw_wrap_b), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
